// File: rtl/simple_fifo_param.sv
// Parametrised single-clock synchronous FIFO with optional first-word-fall-through
// read mode, programmable almost-full/almost-empty flags and sticky error flags.
module simple_fifo_param #(
    parameter int unsigned WIDTH    = 64,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned FWFT     = 0,
    parameter int unsigned AF_LEVEL = 6,
    parameter int unsigned AE_LEVEL = 1,
    localparam int unsigned CW      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [WIDTH-1:0] din,
    input  logic             re,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic             almost_empty,
    output logic             almost_full,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr_inc;
    logic [PW-1:0]    rd_ptr_inc;
    logic [PW-1:0]    head_idx;
    logic             rd_acc;
    logic             wr_acc;
    logic [CW-1:0]    count_next;
    logic [WIDTH-1:0] dout_next;

    // Acceptance, pointer wrap (also for non-power-of-two depth) and next occupancy
    always_comb begin
        rd_acc     = re & ~empty;
        wr_acc     = we & (~full | rd_acc);
        wr_ptr_inc = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
        rd_ptr_inc = (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
        count_next = count + CW'(wr_acc) - CW'(rd_acc);
    end

    // Next read data: popped word in standard mode, next head word in FWFT mode
    always_comb begin
        dout_next = dout;
        head_idx  = rd_acc ? rd_ptr_inc : rd_ptr;
        if (FWFT != 0) begin
            // The head may be the word being written this edge (empty or last-word pop)
            if (count_next != '0) begin
                if (wr_acc && (head_idx == wr_ptr)) begin
                    dout_next = din;
                end else begin
                    dout_next = mem[head_idx];
                end
            end
        end else if (rd_acc) begin
            dout_next = mem[rd_ptr];
        end
    end

    // Storage array; not cleared by reset, writes suppressed while in reset
    always_ff @(posedge clk) begin
        if (reset && wr_acc) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers, occupancy, registered status flags, sticky errors and read data
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
            dout         <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr_inc;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr_inc;
            end
            count        <= count_next;
            empty        <= (count_next == '0);
            full         <= (count_next == CW'(DEPTH));
            almost_empty <= (count_next <= CW'(AE_LEVEL));
            almost_full  <= (count_next >= CW'(AF_LEVEL));
            if (we && !wr_acc) begin
                overflow <= 1'b1;
            end
            if (re && empty) begin
                underflow <= 1'b1;
            end
            dout <= dout_next;
        end
    end

endmodule

// File: tb/tb_simple_fifo_param.sv
// Directed self-checking bench for simple_fifo_param: standard DEPTH=8,
// standard DEPTH=5 (wrap) and FWFT DEPTH=8 instances.
`timescale 1ns/1ps
module tb_simple_fifo_param;

    localparam int unsigned W = 8;

    logic clk;
    logic rst_n;

    // Standard mode, DEPTH 8
    logic         a_we, a_re, a_empty, a_full, a_ae, a_af, a_ovf, a_unf;
    logic [W-1:0] a_din, a_dout;
    logic [3:0]   a_count;
    // Standard mode, DEPTH 5
    logic         b_we, b_re, b_empty, b_full, b_ae, b_af, b_ovf, b_unf;
    logic [W-1:0] b_din, b_dout;
    logic [2:0]   b_count;
    // FWFT mode, DEPTH 8
    logic         c_we, c_re, c_empty, c_full, c_ae, c_af, c_ovf, c_unf;
    logic [W-1:0] c_din, c_dout;
    logic [3:0]   c_count;

    int n_cmp = 0;
    int n_err = 0;

    simple_fifo_param #(.WIDTH(W), .DEPTH(8), .FWFT(0), .AF_LEVEL(6), .AE_LEVEL(1)) u_std (
        .clk(clk), .reset(rst_n), .we(a_we), .din(a_din), .re(a_re), .dout(a_dout),
        .empty(a_empty), .full(a_full), .almost_empty(a_ae), .almost_full(a_af),
        .count(a_count), .overflow(a_ovf), .underflow(a_unf)
    );

    simple_fifo_param #(.WIDTH(W), .DEPTH(5), .FWFT(0), .AF_LEVEL(4), .AE_LEVEL(1)) u_d5 (
        .clk(clk), .reset(rst_n), .we(b_we), .din(b_din), .re(b_re), .dout(b_dout),
        .empty(b_empty), .full(b_full), .almost_empty(b_ae), .almost_full(b_af),
        .count(b_count), .overflow(b_ovf), .underflow(b_unf)
    );

    simple_fifo_param #(.WIDTH(W), .DEPTH(8), .FWFT(1), .AF_LEVEL(6), .AE_LEVEL(1)) u_fw (
        .clk(clk), .reset(rst_n), .we(c_we), .din(c_din), .re(c_re), .dout(c_dout),
        .empty(c_empty), .full(c_full), .almost_empty(c_ae), .almost_full(c_af),
        .count(c_count), .overflow(c_ovf), .underflow(c_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample and drive 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        a_we = 1'b0; a_re = 1'b0; a_din = '0;
        b_we = 1'b0; b_re = 1'b0; b_din = '0;
        c_we = 1'b0; c_re = 1'b0; c_din = '0;

        // Reset with we=re=1 held for two cycles
        a_we = 1'b1; a_re = 1'b1; a_din = 8'h77;
        b_we = 1'b1; b_re = 1'b1; b_din = 8'h77;
        c_we = 1'b1; c_re = 1'b1; c_din = 8'h77;
        tick(); tick();
        check("rst_count", 64'(a_count), 64'd0);
        check("rst_empty", 64'(a_empty), 64'd1);
        check("rst_ae", 64'(a_ae), 64'd1);
        check("rst_full", 64'(a_full), 64'd0);
        check("rst_af", 64'(a_af), 64'd0);
        check("rst_ovf", 64'(a_ovf), 64'd0);
        check("rst_unf", 64'(a_unf), 64'd0);
        check("rst_dout", 64'(a_dout), 64'd0);
        check("rst_d5_count", 64'(b_count), 64'd0);
        check("rst_fw_empty", 64'(c_empty), 64'd1);
        a_we = 1'b0; a_re = 1'b0;
        b_we = 1'b0; b_re = 1'b0;
        c_we = 1'b0; c_re = 1'b0;
        rst_n = 1'b1;
        tick();

        // Fill 1..8, watching almost_empty, almost_full and full thresholds
        a_we = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            a_din = 8'(i);
            tick();
            check($sformatf("fill_count_%0d", i), 64'(a_count), 64'(i));
            check($sformatf("fill_ae_%0d", i), 64'(a_ae), 64'(i <= 1));
            check($sformatf("fill_af_%0d", i), 64'(a_af), 64'(i >= 6));
            check($sformatf("fill_full_%0d", i), 64'(a_full), 64'(i == 8));
        end
        a_we = 1'b0;
        // Drain: each word visible the cycle after its re
        a_re = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check($sformatf("drain_dout_%0d", i), 64'(a_dout), 64'(i));
        end
        a_re = 1'b0;
        check("drain_empty", 64'(a_empty), 64'd1);
        check("drain_count", 64'(a_count), 64'd0);
        tick();
        check("drain_dout_hold", 64'(a_dout), 64'd8);

        // Refill 0x11..0x18, then write while full
        a_we = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            a_din = 8'(8'h10 + i);
            tick();
        end
        check("refill_full", 64'(a_full), 64'd1);
        a_din = 8'hAA;
        tick();
        a_we = 1'b0;
        check("ovf_flag", 64'(a_ovf), 64'd1);
        check("ovf_count", 64'(a_count), 64'd8);
        check("ovf_unf_clear", 64'(a_unf), 64'd0);
        a_re = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check($sformatf("ovf_drain_%0d", i), 64'(a_dout), 64'(8'h10 + i));
        end
        check("ovf_drain_empty", 64'(a_empty), 64'd1);
        // Read on empty
        tick();
        a_re = 1'b0;
        check("unf_flag", 64'(a_unf), 64'd1);
        check("unf_dout_hold", 64'(a_dout), 64'h18);
        check("unf_count", 64'(a_count), 64'd0);
        check("ovf_sticky", 64'(a_ovf), 64'd1);

        // DEPTH 5: preload 1,2,3 then 20 cycles of we&re across pointer wrap
        b_we = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            b_din = 8'(i);
            tick();
        end
        b_re = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            b_din = 8'(i + 3);
            tick();
            check($sformatf("wrap_dout_%0d", i), 64'(b_dout), 64'(i));
            check($sformatf("wrap_count_%0d", i), 64'(b_count), 64'd3);
        end
        b_re = 1'b0;
        // Contents now 21,22,23; add 24,25 to fill
        for (int i = 24; i <= 25; i++) begin
            b_din = 8'(i);
            tick();
        end
        check("d5_full", 64'(b_full), 64'd1);
        check("d5_count5", 64'(b_count), 64'd5);
        b_re = 1'b1;
        b_din = 8'd26;
        tick();
        b_we = 1'b0; b_re = 1'b0;
        check("d5_both_full_count", 64'(b_count), 64'd5);
        check("d5_both_full_full", 64'(b_full), 64'd1);
        check("d5_both_full_ovf", 64'(b_ovf), 64'd0);
        check("d5_both_full_dout", 64'(b_dout), 64'd21);

        // FWFT: write into empty shows the word without re
        c_we = 1'b1; c_din = 8'h11;
        tick();
        c_we = 1'b0;
        check("fw_empty_fall", 64'(c_empty), 64'd0);
        check("fw_head", 64'(c_dout), 64'h11);
        tick();
        check("fw_head_hold", 64'(c_dout), 64'h11);
        c_re = 1'b1;
        tick();
        c_re = 1'b0;
        check("fw_pop_empty", 64'(c_empty), 64'd1);
        // we&re on empty: write only, underflow set
        c_we = 1'b1; c_re = 1'b1; c_din = 8'h22;
        tick();
        c_re = 1'b0;
        check("fw_unf", 64'(c_unf), 64'd1);
        check("fw_unf_count", 64'(c_count), 64'd1);
        check("fw_unf_head", 64'(c_dout), 64'h22);
        c_din = 8'h33;
        tick();
        c_we = 1'b0;
        check("fw_head_keep", 64'(c_dout), 64'h22);
        c_re = 1'b1;
        tick();
        c_re = 1'b0;
        check("fw_next_head", 64'(c_dout), 64'h33);
        check("fw_next_count", 64'(c_count), 64'd1);

        // Reset mid-stream at count 4 on the standard FIFO
        a_we = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            a_din = 8'(8'h40 + i);
            tick();
        end
        a_we = 1'b0;
        check("mid_count4", 64'(a_count), 64'd4);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_count", 64'(a_count), 64'd0);
        check("mid_rst_empty", 64'(a_empty), 64'd1);
        check("mid_rst_ovf", 64'(a_ovf), 64'd0);
        check("mid_rst_unf", 64'(a_unf), 64'd0);
        check("mid_rst_dout", 64'(a_dout), 64'd0);
        a_we = 1'b1; a_din = 8'h05;
        tick();
        a_we = 1'b0; a_re = 1'b1;
        tick();
        a_re = 1'b0;
        check("post_rst_dout", 64'(a_dout), 64'h05);
        check("post_rst_empty", 64'(a_empty), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
